blood_sprite_reader: RTL and testbench

Reads the 64x64 12-bit blood-splatter sprite ROMs and composites the active animation frame onto the VGA pixel stream. Sits between the VGA timing generator / background path and the RGB output register, acting as the consumer of the per-frame blood sprite ROMs (row/col in, registered-address color out). Runs a triggered one-shot animation: plays NUM_FRAMES frames, holds the last, then returns to idle.

---
 rtl/fighter_gfx_pkg.sv | 16 +
 rtl/blood_anim_ctrl.sv | 80 ++++++++
 rtl/blood_sprite_reader.sv | 118 +++++++++++
 tb/tb_blood_sprite_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fighter_gfx_pkg.sv
// Shared graphics types and constants for the fighter sprite pipeline.
package fighter_gfx_pkg;

  typedef logic [11:0] color_t;

  localparam color_t TRANSPARENT_RGB = 12'h000;
  localparam int     SPRITE_DIM      = 64;
  localparam int     SPRITE_AW       = $clog2(SPRITE_DIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } anim_state_t;

endpackage

// File: rtl/blood_anim_ctrl.sv
// One-shot blood animation sequencer: steps frames on frame_tick, holds
// the last frame, then idles. trigger restarts from frame 0 at any time.
module blood_anim_ctrl
  import fighter_gfx_pkg::*;
#(
  parameter int NUM_FRAMES  = 8,
  parameter int FRAME_TICKS = 4,
  parameter int HOLD_TICKS  = 8,
  parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               trigger,
  output logic               busy,
  output logic [FRAME_W-1:0] rom_frame
);

  localparam int TICK_MAX = (FRAME_TICKS > HOLD_TICKS) ? FRAME_TICKS : HOLD_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0]  FT_LAST = TICK_W'(FRAME_TICKS - 1);
  localparam logic [TICK_W-1:0]  HT_LAST = TICK_W'(HOLD_TICKS - 1);
  localparam logic [FRAME_W-1:0] NF_LAST = FRAME_W'(NUM_FRAMES - 1);

  anim_state_t        state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;

  // State, tick counter and frame index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  // Next-state logic; trigger takes priority over a coincident frame_tick.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    frame_idx_d = frame_idx_q;
    if (trigger) begin
      state_d     = PLAY;
      tick_cnt_d  = '0;
      frame_idx_d = '0;
    end else if (frame_tick) begin
      case (state_q)
        PLAY: begin
          if (tick_cnt_q == FT_LAST) begin
            tick_cnt_d = '0;
            if (frame_idx_q == NF_LAST) state_d = HOLD;
            else                        frame_idx_d = frame_idx_q + 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (tick_cnt_q == HT_LAST) begin
            state_d     = IDLE;
            tick_cnt_d  = '0;
            frame_idx_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign rom_frame = frame_idx_q;

endmodule

// File: rtl/blood_sprite_reader.sv
// Composites the active blood-splatter animation frame onto the VGA pixel
// stream. Hit test and ROM addressing are combinational; a one-stage delay
// aligns hit/bg/video_on with the synchronous ROM, then rgb_out registers.
// Optional: BLOOD_MIRROR_EN adds a facing port that mirrors the sprite
// horizontally; facing is latched on trigger.
module blood_sprite_reader
  import fighter_gfx_pkg::*;
#(
  parameter int     NUM_FRAMES  = 8,
  parameter int     FRAME_TICKS = 4,
  parameter int     HOLD_TICKS  = 8,
  parameter color_t TRANSPARENT = TRANSPARENT_RGB,
  parameter int     FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 trigger,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  input  logic                 video_on,
  input  color_t               bg_rgb,
  output logic [SPRITE_AW-1:0] rom_row,
  output logic [SPRITE_AW-1:0] rom_col,
  output logic [FRAME_W-1:0]   rom_frame,
  input  color_t               rom_data,
  output color_t               rgb_out,
`ifdef BLOOD_MIRROR_EN
  input  logic                 facing,
`endif
  output logic                 busy
);

  localparam logic [10:0]          DIM11   = 11'(SPRITE_DIM);
  localparam logic [SPRITE_AW-1:0] COL_MAX = SPRITE_AW'(SPRITE_DIM - 1);

  logic [10:0] dx, dy;
  logic        hit;
  logic        hit_q, hit_d;
  logic        video_on_q, video_on_d;
  color_t      bg_rgb_q, bg_rgb_d;
  color_t      rgb_out_q, rgb_out_d;

  blood_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_TICKS(FRAME_TICKS),
    .HOLD_TICKS (HOLD_TICKS),
    .FRAME_W    (FRAME_W)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .trigger   (trigger),
    .busy      (busy),
    .rom_frame (rom_frame)
  );

`ifdef BLOOD_MIRROR_EN
  logic facing_q, facing_d;

  // Orientation is captured with the trigger so it cannot change mid-animation.
  always_comb facing_d = trigger ? facing : facing_q;

  // Latched facing register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) facing_q <= 1'b0;
    else          facing_q <= facing_d;
  end
`endif

  // Hit test in 11 bits so a pixel left of / above the sprite goes negative
  // instead of wrapping into the box; misses drive address 0.
  always_comb begin
    dx      = {1'b0, pix_x} - {1'b0, pos_x};
    dy      = {1'b0, pix_y} - {1'b0, pos_y};
    hit     = video_on & busy & ~dx[10] & ~dy[10] & (dx < DIM11) & (dy < DIM11);
    rom_row = '0;
    rom_col = '0;
    if (hit) begin
      rom_row = dy[SPRITE_AW-1:0];
      rom_col = dx[SPRITE_AW-1:0];
`ifdef BLOOD_MIRROR_EN
      if (facing_q) rom_col = COL_MAX - dx[SPRITE_AW-1:0];
`endif
    end
  end

  // Delay stage alignment and compositing; transparent ROM texels show bg.
  always_comb begin
    hit_d      = hit;
    video_on_d = video_on;
    bg_rgb_d   = bg_rgb;
    rgb_out_d  = '0;
    if (video_on_q) begin
      rgb_out_d = (hit_q && rom_data != TRANSPARENT) ? rom_data : bg_rgb_q;
    end
  end

  // Pixel pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q      <= 1'b0;
      video_on_q <= 1'b0;
      bg_rgb_q   <= '0;
      rgb_out_q  <= '0;
    end else begin
      hit_q      <= hit_d;
      video_on_q <= video_on_d;
      bg_rgb_q   <= bg_rgb_d;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign rgb_out = rgb_out_q;

endmodule

// File: tb/tb_blood_sprite_reader.sv
// Directed bench for blood_sprite_reader (default parameters).
module tb_blood_sprite_reader;
  import fighter_gfx_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       trigger = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pos_x = '0, pos_y = '0, pix_x = '0, pix_y = '0;
  color_t     bg_rgb = '0, rom_data = '0, rom_fill = '0, rgb_out;
  logic [5:0] rom_row, rom_col;
  logic [2:0] rom_frame;
  logic       busy;
`ifdef BLOOD_MIRROR_EN
  logic       facing = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  color_t hist [0:7];

  always #5 clk = ~clk;

  // Synchronous ROM stand-in: one-cycle read latency, content set by bench.
  always_ff @(posedge clk) rom_data <= rom_fill;

  blood_sprite_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .trigger   (trigger),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .video_on  (video_on),
    .bg_rgb    (bg_rgb),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .rom_frame (rom_frame),
    .rom_data  (rom_data),
    .rgb_out   (rgb_out),
`ifdef BLOOD_MIRROR_EN
    .facing    (facing),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
  endtask

  task automatic trig();
    trigger = 1'b1; cyc(1); trigger = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    pix_x = x; pix_y = y; #1;
  endtask

  initial begin
    // Reset held with pixel stream running.
    video_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bg_rgb = 12'h100 + 12'(i); pix_x = 10'(i);
      cyc(1);
      chk("rst_rgb", rgb_out, 12'h000);
    end
    chk("rst_busy", busy, 0);
    chk("rst_frame", rom_frame, 0);

    // Release, no trigger: rgb_out follows bg two cycles late.
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hist[i] = 12'hA00 + 12'(i * 17);
      bg_rgb = hist[i];
      cyc(1);
      if (i >= 1) chk("bg_pass", rgb_out, {20'h0, hist[i-1]});
    end
    video_on = 1'b0; cyc(2);
    chk("blank_rgb", rgb_out, 12'h000);
    video_on = 1'b1;

    // Full animation: 8 frames x 4 ticks, 8 hold ticks.
    trig();
    chk("trig_busy", busy, 1);
    chk("trig_frame", rom_frame, 0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      chk("seq_frame", rom_frame, (n >= 40) ? 0 : (n >= 32) ? 7 : n / 4);
      chk("seq_busy", busy, (n < 40) ? 1 : 0);
    end
    tick();
    chk("idle_stay", busy, 0);

    // Hit test and compositing around pos=(100,50).
    trig();
    pos_x = 10'd100; pos_y = 10'd50; bg_rgb = 12'h123; rom_fill = 12'hE00;
    pix(10'd99, 10'd50);
    chk("left_row", rom_row, 0); chk("left_col", rom_col, 0);
    cyc(3);
    chk("left_rgb", rgb_out, 12'h123);
    pix(10'd100, 10'd50);
    chk("tl_row", rom_row, 0); chk("tl_col", rom_col, 0);
    cyc(1);
    chk("lat1_rgb", rgb_out, 12'h123);
    cyc(1);
    chk("lat2_rgb", rgb_out, 12'hE00);
    pix(10'd163, 10'd113);
    chk("br_row", rom_row, 63); chk("br_col", rom_col, 63);
    cyc(2);
    chk("br_rgb", rgb_out, 12'hE00);
    pix(10'd105, 10'd60);
    chk("mid_row", rom_row, 10); chk("mid_col", rom_col, 5);
    pix(10'd164, 10'd50);
    chk("right_row", rom_row, 0); chk("right_col", rom_col, 0);
    cyc(2);
    chk("right_rgb", rgb_out, 12'h123);
    pix(10'd100, 10'd114);
    cyc(2);
    chk("below_rgb", rgb_out, 12'h123);
    pix(10'd120, 10'd70); rom_fill = 12'h000;
    chk("in_row", rom_row, 20); chk("in_col", rom_col, 20);
    cyc(2);
    chk("transp_rgb", rgb_out, 12'h123);
    rom_fill = 12'hE00; video_on = 1'b0; #1;
    chk("off_col", rom_col, 0);
    cyc(2);
    chk("off_rgb", rgb_out, 12'h000);
    video_on = 1'b1;

    // Restart from HOLD with a coincident frame_tick.
    trig();
    for (int n = 0; n < 34; n++) tick();
    chk("hold_busy", busy, 1);
    chk("hold_frame", rom_frame, 7);
    trigger = 1'b1; frame_tick = 1'b1; cyc(1);
    trigger = 1'b0; frame_tick = 1'b0;
    chk("retrig_busy", busy, 1);
    chk("retrig_frame", rom_frame, 0);
    for (int n = 0; n < 4; n++) tick();
    chk("retrig_step", rom_frame, 1);

    // Asynchronous reset mid-PLAY.
    #2 reset_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_frame", rom_frame, 0);
    chk("arst_rgb", rgb_out, 12'h000);
    cyc(2);
    chk("arst_hold_rgb", rgb_out, 12'h000);
    reset_n = 1'b1; cyc(1);
    chk("arst_rel_busy", busy, 0);

`ifdef BLOOD_MIRROR_EN
    // Mirroring latched at trigger.
    facing = 1'b1; trig(); facing = 1'b0;
    pix(10'd100, 10'd50);
    chk("mir_col0", rom_col, 63);
    pix(10'd110, 10'd50);
    chk("mir_col10", rom_col, 53);
    trig();
    pix(10'd110, 10'd50);
    chk("nomir_col10", rom_col, 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
